// File: rtl/orao_vram_pkg.sv
// orao_vram_pkg: shared widths, grant encoding and write-FIFO entry for the VRAM arbiter
package orao_vram_pkg;
  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 8;
  typedef enum logic [1:0] {GRANT_IDLE, GRANT_DISP, GRANT_WR, GRANT_RD} grant_t;
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } fifo_entry_t;
endpackage

// File: rtl/orao_vram_spram.sv
// orao_vram_spram: inferred single-port synchronous RAM, 1-cycle read, no reset
module orao_vram_spram #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/orao_vram_arbiter.sv
// orao_vram_arbiter: scanout-priority VRAM arbiter with CPU write FIFO; ORAO_VRAM_CLEAR_EN adds a cpu_clr zero sweep
module orao_vram_arbiter
  import orao_vram_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_pixel,
  input  logic              reset_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] dispAddr,
  output logic [DATA_W-1:0] dispData,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
`ifdef ORAO_VRAM_CLEAR_EN
  input  logic              cpu_clr,
`endif
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;
  entry_t            fifo [FIFO_DEPTH];
  entry_t            head;
  logic [PW:0]       wr_ptr, rd_ptr;
  logic              fifo_empty, fifo_full, push, pop, rd_acc, rd_pending, sweep, ram_we;
  logic [ADDR_W-1:0] rd_addr, ram_addr, sweep_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata, disp_hold, rd_hold;
  grant_t            grant, grant_q;
  assign head       = fifo[rd_ptr[PW-1:0]];
  assign fifo_empty = wr_ptr == rd_ptr;
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign cpu_ready  = reset_n && !fifo_full && !rd_pending && !sweep;
  assign busy       = !fifo_empty || rd_pending || sweep;
  assign push       = cpu_req && cpu_ready && cpu_we;
  assign rd_acc     = cpu_req && cpu_ready && !cpu_we;
`ifdef ORAO_VRAM_CLEAR_EN
  logic              clr_active;
  logic [ADDR_W-1:0] clr_addr;
  assign sweep      = clr_active;
  assign sweep_addr = clr_addr;
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      clr_active <= 1'b0;
      clr_addr   <= '0;
    end else if (clr_active) begin
      if (grant == GRANT_WR) begin
        clr_addr <= clr_addr + 1'b1;
        if (&clr_addr) clr_active <= 1'b0;
      end
    end else if (cpu_clr && cpu_ready) begin
      clr_active <= 1'b1;
      clr_addr   <= '0;
    end
  end
`else
  assign sweep      = 1'b0;
  assign sweep_addr = '0;
`endif
  always_comb begin
    grant = disp_req ? GRANT_DISP : (sweep || !fifo_empty) ? GRANT_WR : rd_pending ? GRANT_RD : GRANT_IDLE;
  end
  assign ram_we    = grant == GRANT_WR;
  assign pop       = ram_we && !sweep;
  assign ram_wdata = sweep ? '0 : head.data;
  assign ram_addr  = grant == GRANT_DISP ? dispAddr : grant == GRANT_RD ? rd_addr : sweep ? sweep_addr : head.addr;
  orao_vram_spram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk(clk_pixel), .we(ram_we), .addr(ram_addr), .wdata(ram_wdata), .rdata(ram_rdata)
  );
  always_ff @(posedge clk_pixel) begin
    if (push) fifo[wr_ptr[PW-1:0]] <= '{addr: cpu_addr, data: cpu_wdata};
  end
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_pending <= 1'b0;
      rd_addr    <= '0;
      grant_q    <= GRANT_IDLE;
      disp_hold  <= '0;
      rd_hold    <= '0;
    end else begin
      grant_q <= grant;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (rd_acc) begin
        rd_pending <= 1'b1;
        rd_addr    <= cpu_addr;
      end else if (grant == GRANT_RD) rd_pending <= 1'b0;
      if (grant_q == GRANT_DISP) disp_hold <= ram_rdata;
      if (grant_q == GRANT_RD) rd_hold <= ram_rdata;
    end
  end
  assign dispData   = grant_q == GRANT_DISP ? ram_rdata : disp_hold;
  assign cpu_rdata  = grant_q == GRANT_RD ? ram_rdata : rd_hold;
  assign cpu_rvalid = grant_q == GRANT_RD;
endmodule

// File: tb/tb_orao_vram_arbiter.sv
// tb_orao_vram_arbiter: directed and random checks of orao_vram_arbiter against a queue-based RAM model
module tb_orao_vram_arbiter;
  logic        clk_pixel = 1'b0, reset_n = 1'b1, disp_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [12:0] dispAddr = '0, cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0, dispData, cpu_rdata;
  logic        cpu_ready, cpu_rvalid, busy;
`ifdef ORAO_VRAM_CLEAR_EN
  logic        cpu_clr = 1'b0;
`endif
  orao_vram_arbiter dut (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .disp_req(disp_req), .dispAddr(dispAddr), .dispData(dispData),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
`ifdef ORAO_VRAM_CLEAR_EN
    .cpu_clr(cpu_clr),
`endif
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .busy(busy)
  );
  always #5 clk_pixel = ~clk_pixel;
  typedef struct packed {logic [12:0] a; logic [7:0] d;} wr_t;
  wr_t         wq[$];
  logic [7:0]  mem_m [8192];
  logic [12:0] pool [16];
  bit          rd_pend, e_rv, clr_m;
  logic [12:0] rd_a;
  logic [7:0]  e_disp, e_rdata;
  int          clr_n, vectors, errors;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic dr, input logic [12:0] da, input logic cr, input logic cw,
                     input logic [12:0] ca, input logic [7:0] cd, input logic clr);
    bit rdy;
    @(negedge clk_pixel);
    rdy = reset_n && wq.size() < 4 && !rd_pend && !clr_m;
    chk("cpu_ready", cpu_ready, rdy);
    chk("busy", busy, wq.size() != 0 || rd_pend || clr_m);
    chk("cpu_rvalid", cpu_rvalid, e_rv);
    chk("dispData", dispData, e_disp);
    chk("cpu_rdata", cpu_rdata, e_rdata);
    disp_req = dr; dispAddr = da; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
`ifdef ORAO_VRAM_CLEAR_EN
    cpu_clr = clr;
`endif
    if (!reset_n) return;
    e_rv = 1'b0;
    if (dr) e_disp = mem_m[da];
    else if (clr_m) begin
      mem_m[clr_n] = 8'h00;
      clr_n++;
      if (clr_n == 8192) clr_m = 1'b0;
    end else if (wq.size() != 0) begin
      wr_t w = wq.pop_front();
      mem_m[w.a] = w.d;
    end else if (rd_pend) begin
      e_rdata = mem_m[rd_a];
      e_rv = 1'b1;
      rd_pend = 1'b0;
    end
    if (cr && rdy) begin
      if (cw) wq.push_back({ca, cd});
      else begin
        rd_pend = 1'b1;
        rd_a = ca;
      end
    end
    if (clr && rdy) begin
      clr_m = 1'b1;
      clr_n = 0;
    end
  endtask
  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask
  task automatic do_reset();
    @(negedge clk_pixel);
    reset_n = 1'b0; disp_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
`ifdef ORAO_VRAM_CLEAR_EN
    cpu_clr = 1'b0;
`endif
    wq.delete();
    rd_pend = 1'b0; e_rv = 1'b0; clr_m = 1'b0; e_disp = '0; e_rdata = '0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", cpu_ready, 1'b0);
    chk("rst_rvalid", cpu_rvalid, 1'b0);
    chk("rst_dispData", dispData, 8'h00);
    chk("rst_rdata", cpu_rdata, 8'h00);
    repeat (2) @(negedge clk_pixel);
    reset_n = 1'b1;
  endtask
  task automatic wait_rv(input string tag, input logic [7:0] exp);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      idle();
      seen = cpu_rvalid;
    end
    chk({tag, "_rvalid_seen"}, seen, 1'b1);
    chk({tag, "_rdata"}, cpu_rdata, exp);
  endtask
  initial begin
    pool = '{13'h0000, 13'h0100, 13'h0101, 13'h0102, 13'h0103, 13'h1FFF, 13'h0200, 13'h0201,
             13'h0202, 13'h0203, 13'h0204, 13'h0205, 13'h0A0A, 13'h1555, 13'h0AAA, 13'h1000};
    #2;
    do_reset();
    // test 1: preload 0x5A at 0, then a single scanout read
    cyc(1'b0, '0, 1'b1, 1'b1, 13'h0000, 8'h5A, 1'b0);
    idle(); idle();
    cyc(1'b1, 13'h0000, 1'b0, 1'b0, '0, '0, 1'b0);
    idle();
    chk("t1_dispData", dispData, 8'h5A);
    chk("t1_rvalid", cpu_rvalid, 1'b0);
    // test 2: four writes under continuous scanout fill the FIFO
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 13'h0000, 1'b1, 1'b1, 13'h0100 + 13'(i), 8'h11 * 8'(i + 1), 1'b0);
    cyc(1'b1, 13'h0000, 1'b0, 1'b0, '0, '0, 1'b0);
    chk("t2_ready_full", cpu_ready, 1'b0);
    chk("t2_busy_full", busy, 1'b1);
    repeat (4) idle();
    chk("t2_busy_last", busy, 1'b1);
    idle();
    chk("t2_busy_drained", busy, 1'b0);
    chk("t2_ready_drained", cpu_ready, 1'b1);
    // test 3: write then read 0x1FFF with scanout on alternate cycles
    cyc(1'b1, 13'h0100, 1'b1, 1'b1, 13'h1FFF, 8'hA5, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 13'h1FFF, '0, 1'b0);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 12 && !seen; i++) begin
        cyc(i % 2 == 0, 13'h0101 + 13'(i % 3), 1'b0, 1'b0, '0, '0, 1'b0);
        seen = cpu_rvalid;
      end
      chk("t3_rvalid_seen", seen, 1'b1);
      chk("t3_rdata", cpu_rdata, 8'hA5);
    end
    repeat (3) idle();
    // test 4: idle-bus read latency
    cyc(1'b0, '0, 1'b1, 1'b0, 13'h0100, '0, 1'b0);
    idle();
    chk("t4_ready_wait", cpu_ready, 1'b0);
    chk("t4_rvalid_early", cpu_rvalid, 1'b0);
    idle();
    chk("t4_rvalid", cpu_rvalid, 1'b1);
    chk("t4_rdata", cpu_rdata, 8'h11);
    chk("t4_ready_back", cpu_ready, 1'b1);
    idle();
    chk("t4_rvalid_pulse", cpu_rvalid, 1'b0);
    // random traffic over a small preloaded address pool
    for (int i = 6; i < 16; i++) cyc(1'b0, '0, 1'b1, 1'b1, pool[i], 8'($urandom), 1'b0);
    repeat (2) idle();
    for (int i = 0; i < 500; i++)
      cyc($urandom_range(0, 2) == 0, pool[$urandom_range(0, 15)], 1'($urandom_range(0, 1)),
          $urandom_range(0, 3) != 0, pool[$urandom_range(0, 15)], 8'($urandom), 1'b0);
    repeat (8) idle();
    // test 5: reset with a pending read behind two queued writes
    cyc(1'b1, 13'h0000, 1'b1, 1'b1, 13'h0100, 8'hEE, 1'b0);
    cyc(1'b1, 13'h0000, 1'b1, 1'b1, 13'h0101, 8'hEF, 1'b0);
    cyc(1'b1, 13'h0000, 1'b1, 1'b0, 13'h0102, '0, 1'b0);
    cyc(1'b1, 13'h0000, 1'b0, 1'b0, '0, '0, 1'b0);
    chk("t5_busy_before", busy, 1'b1);
    chk("t5_ready_before", cpu_ready, 1'b0);
    do_reset();
    idle();
    chk("t5_ready_after", cpu_ready, 1'b1);
    chk("t5_busy_after", busy, 1'b0);
    begin
      int rv = 0;
      for (int i = 0; i < 5; i++) begin
        idle();
        rv += int'(cpu_rvalid);
      end
      chk("t5_no_rvalid", rv, 0);
    end
    cyc(1'b0, '0, 1'b1, 1'b0, 13'h0102, '0, 1'b0);
    wait_rv("t5_read", mem_m[13'h0102]);
`ifdef ORAO_VRAM_CLEAR_EN
    // test 6: clear sweep
    cyc(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    begin
      int n = 0;
      for (int i = 0; i < 9000; i++) begin
        idle();
        if (!busy) break;
        n++;
      end
      chk("t6_busy_cycles", n, 8192);
    end
    cyc(1'b0, '0, 1'b1, 1'b0, 13'h1FFF, '0, 1'b0);
    wait_rv("t6_read", 8'h00);
`endif
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
